// File: rtl/seq_cla_adder_if.sv
// Request/result bundle for the multi-cycle CLA adder/subtractor.
// The requester drives the master side; the adder implements the slave side.
interface seq_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic             sub;
    logic             c_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             overflow;
    logic             zero;
    logic             ready;
    logic             busy;

    modport master (
        output en, sub, c_in, a, b,
        input  result, c_out, overflow, zero, ready, busy
    );

    modport slave (
        input  en, sub, c_in, a, b,
        output result, c_out, overflow, zero, ready, busy
    );
endinterface

// File: rtl/seq_cla_adder.sv
// Multi-cycle adder/subtractor: one BLOCK-bit carry-lookahead slice per clock,
// with the inter-slice carry held in a register.
//
// state | meaning
// IDLE  | waiting for en; operands captured on the edge that sees en=1
// CALC  | one slice per edge, LSB slice first; en low aborts
// DONE  | result and flags valid (ready=1) until en drops
module seq_cla_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input logic           clk,
    input logic           rst,
    seq_cla_adder_if.slave bus
);
    localparam int NBLK = WIDTH / BLOCK;
    localparam int IDXW = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBLK - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry;
    logic [IDXW-1:0]  idx;

    logic [BLOCK-1:0] sl_a;
    logic [BLOCK-1:0] sl_b;
    logic [BLOCK-1:0] sl_g;
    logic [BLOCK-1:0] sl_p;
    logic [BLOCK-1:0] sl_sum;
    logic [BLOCK:0]   sl_c;
    logic [WIDTH-1:0] result_next;

    // Each slice carry is a flat sum of generate/propagate products, not a ripple.
    always_comb begin
        sl_a    = opa[idx*BLOCK +: BLOCK];
        sl_b    = opb[idx*BLOCK +: BLOCK];
        sl_g    = sl_a & sl_b;
        sl_p    = sl_a ^ sl_b;
        sl_c    = '0;
        sl_c[0] = carry;
        for (int i = 0; i < BLOCK; i++) begin
            logic acc;
            logic pp;
            acc = sl_g[i];
            pp  = sl_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & sl_g[j]);
                pp  = pp & sl_p[j];
            end
            sl_c[i+1] = acc | (pp & carry);
        end
        sl_sum      = sl_p ^ sl_c[BLOCK-1:0];
        result_next = bus.result;
        result_next[idx*BLOCK +: BLOCK] = sl_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            opa          <= '0;
            opb          <= '0;
            carry        <= 1'b0;
            idx          <= '0;
            bus.result   <= '0;
            bus.c_out    <= 1'b0;
            bus.overflow <= 1'b0;
            bus.zero     <= 1'b0;
            bus.ready    <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        opa          <= bus.a;
                        opb          <= bus.sub ? ~bus.b : bus.b;
                        // subtract is A + ~B + 1, so the incoming carry is forced high
                        carry        <= bus.sub | bus.c_in;
                        idx          <= '0;
                        bus.result   <= '0;
                        bus.c_out    <= 1'b0;
                        bus.overflow <= 1'b0;
                        bus.zero     <= 1'b0;
                        bus.ready    <= 1'b0;
                        bus.busy     <= 1'b1;
                        state        <= CALC;
                    end
                end
                CALC: begin
                    if (!bus.en) begin
                        bus.busy  <= 1'b0;
                        bus.ready <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        bus.result <= result_next;
                        carry      <= sl_c[BLOCK];
                        idx        <= idx + IDXW'(1);
                        if (idx == LAST_IDX) begin
                            bus.c_out    <= sl_c[BLOCK];
                            bus.overflow <= sl_c[BLOCK] ^ sl_c[BLOCK-1];
                            bus.zero     <= (result_next == '0);
                            bus.ready    <= 1'b1;
                            bus.busy     <= 1'b0;
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!bus.en) begin
                        bus.ready <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_cla_adder.sv
// Bench for seq_cla_adder: vector table plus random ops through a scoreboard,
// then abort, mid-operation reset and a 32/8 configuration.
module tb_seq_cla_adder;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    seq_cla_adder_if #(.WIDTH(16)) bus16 ();
    seq_cla_adder_if #(.WIDTH(32)) bus32 ();

    seq_cla_adder #(.WIDTH(16), .BLOCK(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    seq_cla_adder #(.WIDTH(32), .BLOCK(8)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] r;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    typedef struct {
        logic        s;
        logic        ci;
        logic [15:0] a;
        logic [15:0] b;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model16(input logic s, input logic ci, input logic [15:0] a,
                                     input logic [15:0] b);
        logic [15:0] bb;
        logic [16:0] full;
        exp_t        e;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {16'd0, (s ? 1'b1 : ci)};
        e.r  = full[15:0];
        e.c  = full[16];
        e.v  = (a[15] == bb[15]) && (full[15] != a[15]);
        e.z  = (full[15:0] == 16'd0);
        return e;
    endfunction

    task automatic run16(input logic s, input logic ci, input logic [15:0] a,
                         input logic [15:0] b, input exp_t e, input string tag);
        exp_t got;
        int   n;
        @(negedge clk);
        bus16.en   = 1'b1;
        bus16.sub  = s;
        bus16.c_in = ci;
        bus16.a    = a;
        bus16.b    = b;
        sb.push_back(e);
        @(posedge clk); #1;
        check({tag, " busy after capture"}, bus16.busy, 1);
        check({tag, " ready after capture"}, bus16.ready, 0);
        bus16.a    = ~a;
        bus16.b    = ~b;
        bus16.sub  = ~s;
        bus16.c_in = ~ci;
        n = 0;
        while (!bus16.ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, n, 4);
        check({tag, " busy at done"}, bus16.busy, 0);
        got = sb.pop_front();
        check({tag, " result"}, bus16.result, got.r);
        check({tag, " c_out"}, bus16.c_out, got.c);
        check({tag, " overflow"}, bus16.overflow, got.v);
        check({tag, " zero"}, bus16.zero, got.z);
        @(posedge clk); #1;
        check({tag, " ready held"}, bus16.ready, 1);
        check({tag, " result held"}, bus16.result, got.r);
        @(negedge clk);
        bus16.en = 1'b0;
        @(posedge clk); #1;
        check({tag, " ready fall"}, bus16.ready, 0);
        check({tag, " result after fall"}, bus16.result, got.r);
    endtask

    initial begin
        int   n;
        exp_t e;
        logic s, ci;
        logic [15:0] ra, rb;

        total = 0;
        bad   = 0;
        vecs[0] = '{1'b0, 1'b0, 16'd127,  16'd127, '{16'd254,  1'b0, 1'b0, 1'b0}};
        vecs[1] = '{1'b0, 1'b1, 16'hFFFF, 16'd0,   '{16'd0,    1'b1, 1'b0, 1'b1}};
        vecs[2] = '{1'b1, 1'b0, 16'd5,    16'd7,   '{16'hFFFE, 1'b0, 1'b0, 1'b0}};
        vecs[3] = '{1'b1, 1'b0, 16'd7,    16'd5,   '{16'd2,    1'b1, 1'b0, 1'b0}};
        vecs[4] = '{1'b0, 1'b0, 16'h7FFF, 16'd1,   '{16'h8000, 1'b0, 1'b1, 1'b0}};
        vecs[5] = '{1'b1, 1'b1, 16'h8000, 16'd1,   '{16'h7FFF, 1'b1, 1'b1, 1'b0}};

        rst = 1'b1;
        bus16.en = 1'b0; bus16.sub = 1'b0; bus16.c_in = 1'b0; bus16.a = '0; bus16.b = '0;
        bus32.en = 1'b0; bus32.sub = 1'b0; bus32.c_in = 1'b0; bus32.a = '0; bus32.b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset result", bus16.result, 0);
        check("reset flags", {bus16.c_out, bus16.overflow, bus16.zero, bus16.ready, bus16.busy}, 0);

        for (int i = 0; i < 6; i++)
            run16(vecs[i].s, vecs[i].ci, vecs[i].a, vecs[i].b, vecs[i].e, $sformatf("vec%0d", i));

        for (int i = 0; i < 8; i++) begin
            s  = 1'($urandom_range(0, 1));
            ci = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = 16'($urandom);
            e  = model16(s, ci, ra, rb);
            run16(s, ci, ra, rb, e, $sformatf("rnd%0d", i));
        end

        // abort after two CALC edges
        @(negedge clk);
        bus16.en = 1'b1; bus16.sub = 1'b0; bus16.c_in = 1'b0;
        bus16.a = 16'd100; bus16.b = 16'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus16.en = 1'b0;
        n = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus16.ready) n++;
        end
        check("abort ready never", n, 0);
        check("abort busy", bus16.busy, 0);
        check("abort flags", {bus16.c_out, bus16.overflow, bus16.zero}, 0);
        run16(1'b0, 1'b0, 16'd3, 16'd4, '{16'd7, 1'b0, 1'b0, 1'b0}, "after_abort");

        // reset mid-CALC
        @(negedge clk);
        bus16.en = 1'b1; bus16.sub = 1'b0; bus16.c_in = 1'b0;
        bus16.a = 16'hFFFF; bus16.b = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        check("pre-reset busy", bus16.busy, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async reset result", bus16.result, 0);
        check("async reset flags", {bus16.c_out, bus16.overflow, bus16.zero, bus16.ready, bus16.busy}, 0);
        bus16.en = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        run16(1'b0, 1'b0, 16'd9, 16'd9, '{16'd18, 1'b0, 1'b0, 1'b0}, "after_reset");

        // 32-bit, 8-bit slices
        @(negedge clk);
        bus32.en = 1'b1; bus32.sub = 1'b0; bus32.c_in = 1'b0;
        bus32.a = 32'hFFFF_FFFF; bus32.b = 32'd1;
        @(posedge clk); #1;
        check("w32 busy", bus32.busy, 1);
        n = 0;
        while (!bus32.ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("w32 latency", n, 4);
        check("w32 result", bus32.result, 32'd0);
        check("w32 c_out", bus32.c_out, 1);
        check("w32 zero", bus32.zero, 1);
        check("w32 overflow", bus32.overflow, 0);
        @(negedge clk);
        bus32.en = 1'b0;
        @(posedge clk); #1;
        check("w32 ready fall", bus32.ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
